// File: rtl/tank_pkg.sv
// Shared tile codes, response codes, map geometry and the level-1 layout
// for the tank game's tile map and its readers.
package tank_pkg;

  localparam int DEFAULT_MAP_W = 20;
  localparam int DEFAULT_MAP_H = 15;
  localparam int MAP_BITS      = DEFAULT_MAP_W * DEFAULT_MAP_H * 3;

  localparam logic [2:0] TILE_EMPTY   = 3'd0;
  localparam logic [2:0] TILE_BORDER  = 3'd1;
  localparam logic [2:0] TILE_WALL    = 3'd2;
  localparam logic [2:0] TILE_BASE_P1 = 3'd3;
  localparam logic [2:0] TILE_BASE_P2 = 3'd4;
  localparam logic [2:0] TILE_CRACKED = 3'd5;

  typedef enum logic [2:0] {
    RESP_PASS    = 3'd0,
    RESP_CRACK   = 3'd1,
    RESP_DESTROY = 3'd2,
    RESP_SOLID   = 3'd3,
    RESP_BASE    = 3'd4,
    RESP_OOB     = 3'd5
  } resp_code_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE
  } wr_state_e;

  // row*20 + col built from shifts so no multiplier is inferred
  function automatic logic [8:0] tile_index(input logic [4:0] col, input logic [3:0] row);
    return {1'b0, row, 4'b0000} + {3'b000, row, 2'b00} + {4'b0000, col};
  endfunction

  function automatic logic [MAP_BITS-1:0] build_level1();
    logic [MAP_BITS-1:0] m;
    logic [2:0]          t;
    m = '0;
    for (int r = 0; r < DEFAULT_MAP_H; r++) begin
      for (int c = 0; c < DEFAULT_MAP_W; c++) begin
        t = TILE_EMPTY;
        if (r == 0 || r == DEFAULT_MAP_H - 1 || c == 0 || c == DEFAULT_MAP_W - 1)
          t = TILE_BORDER;
        else if ((r == 3 || r == 11) && ((c >= 3 && c <= 6) || (c >= 13 && c <= 16)))
          t = TILE_WALL;
        else if (r == 7 && c >= 5 && c <= 14)
          t = TILE_WALL;
        else if ((r == 1 && (c == 8 || c == 9 || c == 11)) || (r == 13 && (c == 8 || c == 10)))
          t = TILE_WALL;
        if (r == 1 && c == 10)
          t = TILE_BASE_P2;
        if (r == 13 && c == 9)
          t = TILE_BASE_P1;
        m[(r * DEFAULT_MAP_W + c) * 3 +: 3] = t;
      end
    end
    return m;
  endfunction

  localparam logic [MAP_BITS-1:0] LEVEL1_MAP = build_level1();

endpackage

// File: rtl/impact_arbiter.sv
// Two-port round-robin grant for bullet impact requests; remembers which
// player owns the request currently in flight.
module impact_arbiter (
  input  logic Clk,
  input  logic Reset,
  input  logic i_enable,
  input  logic i_valid0,
  input  logic i_valid1,
  output logic o_ready0,
  output logic o_ready1,
  output logic o_gntId,
  output logic o_id
);

  logic r_rrPtr;
  logic r_id;
  logic w_gntId;
  logic w_accept;

  always_comb begin
    w_gntId = 1'b0;
    if (i_valid0 && i_valid1)
      w_gntId = r_rrPtr;
    else if (i_valid1)
      w_gntId = 1'b1;
  end

  assign w_accept = i_enable && (i_valid0 || i_valid1);
  assign o_ready0 = w_accept && !w_gntId;
  assign o_ready1 = w_accept && w_gntId;
  assign o_gntId  = w_gntId;
  assign o_id     = r_id;

  // The pointer only moves on a contested grant, handing priority to the loser
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_rrPtr <= 1'b0;
      r_id    <= 1'b0;
    end else if (w_accept) begin
      r_id <= w_gntId;
      if (i_valid0 && i_valid1)
        r_rrPtr <= ~w_gntId;
    end
  end

endmodule

// File: rtl/tile_map_writer.sv
// Sole writer of the tile map: services bullet impacts from both players,
// damages walls, reports outcomes and latches game-over / winner.
module tile_map_writer
  import tank_pkg::*;
#(
  parameter int MAP_W = DEFAULT_MAP_W,
  parameter int MAP_H = DEFAULT_MAP_H
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     p0_req_valid,
  output logic                     p0_req_ready,
  input  logic [4:0]               p0_req_col,
  input  logic [3:0]               p0_req_row,
  input  logic                     p1_req_valid,
  output logic                     p1_req_ready,
  input  logic [4:0]               p1_req_col,
  input  logic [3:0]               p1_req_row,
  output logic                     resp_valid,
  output logic                     resp_id,
  output logic [2:0]               resp_code,
  output logic [MAP_W*MAP_H*3-1:0] map_out,
  output logic                     game_over,
  output logic [1:0]               winner
);

  wr_state_e r_state, w_nextState;

  logic [MAP_W*MAP_H*3-1:0] r_map;
  logic [4:0]  r_col;
  logic [3:0]  r_row;
  logic [8:0]  r_idx;
  logic [2:0]  r_tile;
  logic        r_oob;
  logic        r_gameOver;
  logic [1:0]  r_winner;

  logic        w_enable;
  logic        w_gntId;
  logic        w_id;
  logic        w_accept;
  logic        w_oob;
  logic [8:0]  w_idx;
  logic [9:0]  w_rdOff;
  logic [9:0]  w_wrOff;
  logic        w_respValid;
  resp_code_e  w_respCode;
  logic        w_mapWe;
  logic [2:0]  w_mapWdata;
  logic        w_baseHit;
  logic [1:0]  w_baseWinner;

  assign w_enable = (r_state == ST_IDLE) && !Reset;
  assign w_accept = p0_req_ready || p1_req_ready;

  impact_arbiter u_arbiter (
    .Clk      (Clk),
    .Reset    (Reset),
    .i_enable (w_enable),
    .i_valid0 (p0_req_valid),
    .i_valid1 (p1_req_valid),
    .o_ready0 (p0_req_ready),
    .o_ready1 (p1_req_ready),
    .o_gntId  (w_gntId),
    .o_id     (w_id)
  );

  assign w_oob   = (r_col >= 5'(MAP_W)) || (r_row >= 4'(MAP_H));
  assign w_idx   = tile_index(r_col, r_row);
  assign w_rdOff = {1'b0, w_idx} + {w_idx, 1'b0};
  assign w_wrOff = {1'b0, r_idx} + {r_idx, 1'b0};

  always_ff @(posedge Clk) begin
    if (Reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState  = r_state;
    w_respValid  = 1'b0;
    w_respCode   = RESP_PASS;
    w_mapWe      = 1'b0;
    w_mapWdata   = TILE_EMPTY;
    w_baseHit    = 1'b0;
    w_baseWinner = 2'd0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept)
          w_nextState = ST_READ;
      end
      ST_READ: begin
        w_nextState = ST_WRITE;
      end
      ST_WRITE: begin
        w_nextState = ST_IDLE;
        w_respValid = 1'b1;
        if (r_oob) begin
          w_respCode = RESP_OOB;
        end else begin
          // Once the game is decided the map is frozen, so walls behave as solid
          case (r_tile)
            TILE_EMPTY: w_respCode = RESP_PASS;
            TILE_WALL: begin
              if (r_gameOver) begin
                w_respCode = RESP_SOLID;
              end else begin
                w_respCode = RESP_CRACK;
                w_mapWe    = 1'b1;
                w_mapWdata = TILE_CRACKED;
              end
            end
            TILE_CRACKED: begin
              if (r_gameOver) begin
                w_respCode = RESP_SOLID;
              end else begin
                w_respCode = RESP_DESTROY;
                w_mapWe    = 1'b1;
                w_mapWdata = TILE_EMPTY;
              end
            end
            TILE_BASE_P1: begin
              w_respCode   = RESP_BASE;
              w_baseHit    = 1'b1;
              w_baseWinner = 2'd2;
            end
            TILE_BASE_P2: begin
              w_respCode   = RESP_BASE;
              w_baseHit    = 1'b1;
              w_baseWinner = 2'd1;
            end
            default: w_respCode = RESP_SOLID;
          endcase
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_col      <= '0;
      r_row      <= '0;
      r_idx      <= '0;
      r_tile     <= TILE_EMPTY;
      r_oob      <= 1'b0;
      r_map      <= LEVEL1_MAP;
      r_gameOver <= 1'b0;
      r_winner   <= 2'd0;
    end else begin
      if (w_accept) begin
        r_col <= w_gntId ? p1_req_col : p0_req_col;
        r_row <= w_gntId ? p1_req_row : p0_req_row;
      end
      if (r_state == ST_READ) begin
        r_oob  <= w_oob;
        r_idx  <= w_idx;
        r_tile <= w_oob ? TILE_EMPTY : r_map[w_rdOff +: 3];
      end
      if (w_mapWe)
        r_map[w_wrOff +: 3] <= w_mapWdata;
      if (w_baseHit && !r_gameOver) begin
        r_gameOver <= 1'b1;
        r_winner   <= w_baseWinner;
      end
    end
  end

  assign resp_valid = w_respValid;
  assign resp_id    = w_id;
  assign resp_code  = w_respCode;
  assign map_out    = r_map;
  assign game_over  = r_gameOver;
  assign winner     = r_winner;

endmodule

// File: tb/tb_tile_map_writer.sv
// Directed self-checking bench for tile_map_writer: impacts, arbitration,
// base hits, out-of-range requests and reset in mid-transaction.
module tb_tile_map_writer;

  localparam logic [2:0] C_PASS    = 3'd0;
  localparam logic [2:0] C_CRACK   = 3'd1;
  localparam logic [2:0] C_DESTROY = 3'd2;
  localparam logic [2:0] C_SOLID   = 3'd3;
  localparam logic [2:0] C_BASE    = 3'd4;
  localparam logic [2:0] C_OOB     = 3'd5;

  logic         Clk;
  logic         Reset;
  logic         p0_req_valid;
  logic         p0_req_ready;
  logic [4:0]   p0_req_col;
  logic [3:0]   p0_req_row;
  logic         p1_req_valid;
  logic         p1_req_ready;
  logic [4:0]   p1_req_col;
  logic [3:0]   p1_req_row;
  logic         resp_valid;
  logic         resp_id;
  logic [2:0]   resp_code;
  logic [899:0] map_out;
  logic         game_over;
  logic [1:0]   winner;

  logic [899:0] expMap;
  int nChecks = 0;
  int nFail   = 0;

  tile_map_writer dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .p0_req_valid (p0_req_valid),
    .p0_req_ready (p0_req_ready),
    .p0_req_col   (p0_req_col),
    .p0_req_row   (p0_req_row),
    .p1_req_valid (p1_req_valid),
    .p1_req_ready (p1_req_ready),
    .p1_req_col   (p1_req_col),
    .p1_req_row   (p1_req_row),
    .resp_valid   (resp_valid),
    .resp_id      (resp_id),
    .resp_code    (resp_code),
    .map_out      (map_out),
    .game_over    (game_over),
    .winner       (winner)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  task automatic setTile(input int c, input int r, input logic [2:0] v);
    expMap[(r * 20 + c) * 3 +: 3] = v;
  endtask

  task automatic buildExpectedMap();
    expMap = '0;
    for (int c = 0; c < 20; c++) begin setTile(c, 0, 3'd1); setTile(c, 14, 3'd1); end
    for (int r = 0; r < 15; r++) begin setTile(0, r, 3'd1); setTile(19, r, 3'd1); end
    for (int k = 0; k < 4; k++) begin
      setTile(3 + k, 3, 3'd2);  setTile(13 + k, 3, 3'd2);
      setTile(3 + k, 11, 3'd2); setTile(13 + k, 11, 3'd2);
    end
    for (int c = 5; c <= 14; c++) setTile(c, 7, 3'd2);
    setTile(8, 1, 3'd2); setTile(9, 1, 3'd2); setTile(11, 1, 3'd2);
    setTile(8, 13, 3'd2); setTile(10, 13, 3'd2);
    setTile(10, 1, 3'd4);
    setTile(9, 13, 3'd3);
  endtask

  // Starts at a negedge in IDLE; returns at the negedge after the response's WRITE cycle
  task automatic doReq(input bit port, input logic [4:0] col, input logic [3:0] row,
                       output bit acc, output logic early, output logic seen,
                       output logic [2:0] code, output logic id);
    acc = 1'b0;
    if (port) begin p1_req_valid = 1'b1; p1_req_col = col; p1_req_row = row; end
    else      begin p0_req_valid = 1'b1; p0_req_col = col; p0_req_row = row; end
    for (int i = 0; i < 10 && !acc; i++) begin
      #1;
      acc = port ? (p1_req_ready === 1'b1) : (p0_req_ready === 1'b1);
      @(negedge Clk);
    end
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
    early = resp_valid;
    @(negedge Clk);
    seen = resp_valid;
    code = resp_code;
    id   = resp_id;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    p0_req_valid = 1'b1; p0_req_col = 5'd8; p0_req_row = 4'd1;
    p1_req_valid = 1'b1; p1_req_col = 5'd8; p1_req_row = 4'd1;
    #1;
    nChecks++; if (p0_req_ready !== 1'b0) begin nFail++; $display("[TB] FAIL rst_ready0 got %b want 0", p0_req_ready); end
    nChecks++; if (p1_req_ready !== 1'b0) begin nFail++; $display("[TB] FAIL rst_ready1 got %b want 0", p1_req_ready); end
    nChecks++; if (resp_valid !== 1'b0) begin nFail++; $display("[TB] FAIL rst_resp_valid got %b want 0", resp_valid); end
    nChecks++; if (game_over !== 1'b0) begin nFail++; $display("[TB] FAIL rst_game_over got %b want 0", game_over); end
    nChecks++; if (winner !== 2'd0) begin nFail++; $display("[TB] FAIL rst_winner got %0d want 0", winner); end
    nChecks++; if (map_out !== expMap) begin nFail++; $display("[TB] FAIL rst_map differs from level-1 layout"); end
    @(negedge Clk);
    Reset = 1'b0;
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
    @(negedge Clk);
    nChecks++; if (resp_valid !== 1'b0) begin nFail++; $display("[TB] FAIL rst_no_resp got %b want 0", resp_valid); end
  endtask

  task automatic test_crack_destroy();
    bit acc; logic early, seen, id; logic [2:0] code;
    doReq(1'b0, 5'd8, 4'd1, acc, early, seen, code, id);
    setTile(8, 1, 3'd5);
    nChecks++; if (!acc) begin nFail++; $display("[TB] FAIL crack_accept got 0 want 1"); end
    nChecks++; if (early !== 1'b0) begin nFail++; $display("[TB] FAIL crack_early_resp got %b want 0", early); end
    nChecks++; if (seen !== 1'b1) begin nFail++; $display("[TB] FAIL crack_resp_valid got %b want 1", seen); end
    nChecks++; if (code !== C_CRACK) begin nFail++; $display("[TB] FAIL crack_code got %0d want %0d", code, C_CRACK); end
    nChecks++; if (id !== 1'b0) begin nFail++; $display("[TB] FAIL crack_id got %b want 0", id); end
    nChecks++; if (map_out[28*3 +: 3] !== 3'd5) begin nFail++; $display("[TB] FAIL crack_tile28 got %0d want 5", map_out[28*3 +: 3]); end
    nChecks++; if (map_out !== expMap) begin nFail++; $display("[TB] FAIL crack_map differs from expected"); end
    nChecks++; if (resp_valid !== 1'b0) begin nFail++; $display("[TB] FAIL crack_pulse_width got %b want 0", resp_valid); end
    doReq(1'b0, 5'd8, 4'd1, acc, early, seen, code, id);
    setTile(8, 1, 3'd0);
    nChecks++; if (!acc || seen !== 1'b1) begin nFail++; $display("[TB] FAIL destroy_handshake got acc=%b resp=%b want 1/1", acc, seen); end
    nChecks++; if (code !== C_DESTROY) begin nFail++; $display("[TB] FAIL destroy_code got %0d want %0d", code, C_DESTROY); end
    nChecks++; if (map_out !== expMap) begin nFail++; $display("[TB] FAIL destroy_map tile28 got %0d want 0", map_out[28*3 +: 3]); end
  endtask

  task automatic test_solid_pass();
    bit acc; logic early, seen, id; logic [2:0] code;
    doReq(1'b1, 5'd0, 4'd0, acc, early, seen, code, id);
    nChecks++; if (!acc || seen !== 1'b1) begin nFail++; $display("[TB] FAIL solid_handshake got acc=%b resp=%b want 1/1", acc, seen); end
    nChecks++; if (code !== C_SOLID) begin nFail++; $display("[TB] FAIL solid_code got %0d want %0d", code, C_SOLID); end
    nChecks++; if (id !== 1'b1) begin nFail++; $display("[TB] FAIL solid_id got %b want 1", id); end
    nChecks++; if (map_out !== expMap) begin nFail++; $display("[TB] FAIL solid_map changed"); end
    doReq(1'b0, 5'd1, 4'd1, acc, early, seen, code, id);
    nChecks++; if (code !== C_PASS || seen !== 1'b1) begin nFail++; $display("[TB] FAIL pass_code got %0d/%b want %0d/1", code, seen, C_PASS); end
    nChecks++; if (id !== 1'b0) begin nFail++; $display("[TB] FAIL pass_id got %b want 0", id); end
  endtask

  task automatic test_arbitration();
    logic [2:0] wantCode;
    bit firstPort;
    for (int rnd = 0; rnd < 2; rnd++) begin
      wantCode  = (rnd == 0) ? C_CRACK : C_DESTROY;
      firstPort = (rnd == 0) ? 1'b0 : 1'b1;
      p0_req_valid = 1'b1; p0_req_col = 5'd3; p0_req_row = 4'd3;
      p1_req_valid = 1'b1; p1_req_col = 5'd4; p1_req_row = 4'd3;
      for (int g = 0; g < 2; g++) begin
        bit expPort;
        expPort = (g == 0) ? firstPort : !firstPort;
        #1;
        nChecks++; if (p0_req_ready !== !expPort || p1_req_ready !== expPort) begin nFail++; $display("[TB] FAIL arb_r%0d_g%0d_ready got %b%b want %b%b", rnd, g, p1_req_ready, p0_req_ready, expPort, !expPort); end
        @(negedge Clk);
        if (expPort) p1_req_valid = 1'b0; else p0_req_valid = 1'b0;
        #1;
        nChecks++; if (p0_req_ready !== 1'b0 || p1_req_ready !== 1'b0) begin nFail++; $display("[TB] FAIL arb_r%0d_g%0d_busy_ready got %b%b want 00", rnd, g, p1_req_ready, p0_req_ready); end
        @(negedge Clk);
        nChecks++; if (resp_valid !== 1'b1 || resp_id !== expPort || resp_code !== wantCode) begin nFail++; $display("[TB] FAIL arb_r%0d_g%0d_resp got v=%b id=%b code=%0d want v=1 id=%b code=%0d", rnd, g, resp_valid, resp_id, resp_code, expPort, wantCode); end
        @(negedge Clk);
      end
      setTile(3, 3, (rnd == 0) ? 3'd5 : 3'd0);
      setTile(4, 3, (rnd == 0) ? 3'd5 : 3'd0);
      nChecks++; if (map_out !== expMap) begin nFail++; $display("[TB] FAIL arb_r%0d_map tiles63/64 got %0d/%0d", rnd, map_out[63*3 +: 3], map_out[64*3 +: 3]); end
    end
  endtask

  task automatic test_base();
    bit acc; logic early, seen, id; logic [2:0] code;
    doReq(1'b0, 5'd9, 4'd13, acc, early, seen, code, id);
    nChecks++; if (code !== C_BASE || seen !== 1'b1) begin nFail++; $display("[TB] FAIL base1_code got %0d/%b want %0d/1", code, seen, C_BASE); end
    nChecks++; if (game_over !== 1'b1) begin nFail++; $display("[TB] FAIL base1_game_over got %b want 1", game_over); end
    nChecks++; if (winner !== 2'd2) begin nFail++; $display("[TB] FAIL base1_winner got %0d want 2", winner); end
    doReq(1'b1, 5'd10, 4'd1, acc, early, seen, code, id);
    nChecks++; if (code !== C_BASE || id !== 1'b1) begin nFail++; $display("[TB] FAIL base2_code got %0d id=%b want %0d id=1", code, id, C_BASE); end
    nChecks++; if (winner !== 2'd2) begin nFail++; $display("[TB] FAIL base2_winner_sticky got %0d want 2", winner); end
    doReq(1'b0, 5'd5, 4'd3, acc, early, seen, code, id);
    nChecks++; if (code !== C_SOLID) begin nFail++; $display("[TB] FAIL frozen_wall_code got %0d want %0d", code, C_SOLID); end
    nChecks++; if (map_out !== expMap) begin nFail++; $display("[TB] FAIL frozen_map tile65 got %0d want 2", map_out[65*3 +: 3]); end
  endtask

  task automatic test_oob();
    bit acc; logic early, seen, id; logic [2:0] code;
    doReq(1'b0, 5'd20, 4'd0, acc, early, seen, code, id);
    nChecks++; if (!acc || seen !== 1'b1 || code !== C_OOB) begin nFail++; $display("[TB] FAIL oob_col got acc=%b v=%b code=%0d want 1/1/%0d", acc, seen, code, C_OOB); end
    doReq(1'b0, 5'd0, 4'd15, acc, early, seen, code, id);
    nChecks++; if (!acc || seen !== 1'b1 || code !== C_OOB) begin nFail++; $display("[TB] FAIL oob_row got acc=%b v=%b code=%0d want 1/1/%0d", acc, seen, code, C_OOB); end
    nChecks++; if (map_out !== expMap) begin nFail++; $display("[TB] FAIL oob_map changed"); end
    nChecks++; if (game_over !== 1'b1 || winner !== 2'd2) begin nFail++; $display("[TB] FAIL oob_game_state got %b/%0d want 1/2", game_over, winner); end
  endtask

  task automatic test_reset_mid();
    bit acc; logic early, seen, id; logic [2:0] code;
    p0_req_valid = 1'b1; p0_req_col = 5'd5; p0_req_row = 4'd3;
    #1;
    nChecks++; if (p0_req_ready !== 1'b1) begin nFail++; $display("[TB] FAIL rmid_accept got %b want 1", p0_req_ready); end
    @(negedge Clk);
    p0_req_valid = 1'b0;
    Reset = 1'b1;
    p1_req_valid = 1'b1; p1_req_col = 5'd1; p1_req_row = 4'd1;
    #1;
    nChecks++; if (p0_req_ready !== 1'b0 || p1_req_ready !== 1'b0) begin nFail++; $display("[TB] FAIL rmid_ready_in_reset got %b%b want 00", p1_req_ready, p0_req_ready); end
    @(negedge Clk);
    nChecks++; if (resp_valid !== 1'b0) begin nFail++; $display("[TB] FAIL rmid_dropped_resp got %b want 0", resp_valid); end
    Reset = 1'b0;
    p1_req_valid = 1'b0;
    buildExpectedMap();
    nChecks++; if (map_out !== expMap) begin nFail++; $display("[TB] FAIL rmid_map differs from level-1 layout"); end
    nChecks++; if (game_over !== 1'b0 || winner !== 2'd0) begin nFail++; $display("[TB] FAIL rmid_game_state got %b/%0d want 0/0", game_over, winner); end
    @(negedge Clk);
    nChecks++; if (resp_valid !== 1'b0) begin nFail++; $display("[TB] FAIL rmid_late_resp got %b want 0", resp_valid); end
    doReq(1'b0, 5'd5, 4'd3, acc, early, seen, code, id);
    setTile(5, 3, 3'd5);
    nChecks++; if (!acc || early !== 1'b0 || seen !== 1'b1 || code !== C_CRACK || id !== 1'b0) begin nFail++; $display("[TB] FAIL rmid_after got acc=%b e=%b v=%b code=%0d id=%b want 1/0/1/%0d/0", acc, early, seen, code, id, C_CRACK); end
    nChecks++; if (map_out !== expMap) begin nFail++; $display("[TB] FAIL rmid_after_map tile65 got %0d want 5", map_out[65*3 +: 3]); end
  endtask

  initial begin
    Reset = 1'b1;
    p0_req_valid = 1'b0; p0_req_col = '0; p0_req_row = '0;
    p1_req_valid = 1'b0; p1_req_col = '0; p1_req_row = '0;
    buildExpectedMap();
    test_reset();
    test_crack_destroy();
    test_solid_pass();
    test_arbitration();
    test_base();
    test_oob();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
